// File: rtl/seq_mul_pkg.sv
// Shared encodings for the sequential shift-add multiplier family.
package seq_mul_pkg;

  // RISC-V M-extension multiply flavours, as presented on the mode port.
  localparam logic [1:0] MODE_MUL    = 2'b00;
  localparam logic [1:0] MODE_MULH   = 2'b01;
  localparam logic [1:0] MODE_MULHSU = 2'b10;
  localparam logic [1:0] MODE_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } state_t;

  // rs1 is treated as signed for MULH and MULHSU.
  function automatic logic mode_a_signed(input logic [1:0] m);
    return (m == MODE_MULH) || (m == MODE_MULHSU);
  endfunction

  // rs2 is treated as signed for MULH only.
  function automatic logic mode_b_signed(input logic [1:0] m);
    return (m == MODE_MULH);
  endfunction

endpackage

// File: rtl/seq_mul_signfix.sv
// Conditional two's-complement: negates i_val when i_neg is set.
// The most-negative input maps onto itself, which read as unsigned is its magnitude.
module seq_mul_signfix #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_val,
  input  logic         i_neg,
  output logic [W-1:0] o_val
);

  assign o_val = i_neg ? (~i_val + {{(W-1){1'b0}}, 1'b1}) : i_val;

endmodule

// File: rtl/seq_mul_param.sv
// Multi-cycle shift-add multiplier with start/busy/done handshake, abort,
// and the four RISC-V multiply modes. Operates on magnitudes and fixes the
// sign of the full product in a final cycle.
module seq_mul_param
  import seq_mul_pkg::*;
#(
  parameter  int WIDTH = 64,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     result
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_mode;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_busy;
  logic                 r_done;
  logic [2*WIDTH-1:0]   r_product;
  logic [WIDTH-1:0]     r_result;

  logic                 w_sa;
  logic                 w_sb;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic                 w_last;

  assign w_sa   = mode_a_signed(mode) & multiplicand[WIDTH-1];
  assign w_sb   = mode_b_signed(mode) & multiplier[WIDTH-1];
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  // The accumulator is WIDTH+1 bits so the carry of each partial add survives the shift.
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

  seq_mul_signfix #(.W(WIDTH)) u_fix_a (
    .i_val (multiplicand),
    .i_neg (w_sa),
    .o_val (w_mag_a)
  );

  seq_mul_signfix #(.W(WIDTH)) u_fix_b (
    .i_val (multiplier),
    .i_neg (w_sb),
    .o_val (w_mag_b)
  );

  // A zero magnitude negates to zero, so no negative zero can appear.
  seq_mul_signfix #(.W(2*WIDTH)) u_fix_p (
    .i_val ({r_hi, r_lo}),
    .i_neg (r_neg),
    .o_val (w_prod_fix)
  );

  // State register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: start only from IDLE, abort cancels CALC/FIX.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_CALC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_FIX;
        end else begin
          w_state_nxt = ST_CALC;
        end
      end
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, one multiplier bit per cycle, sign fix and outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_mode    <= MODE_MUL;
      r_neg     <= 1'b0;
      r_mcand   <= {WIDTH{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_cnt     <= {CNT_W{1'b0}};
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= {(2*WIDTH){1'b0}};
      r_result  <= {WIDTH{1'b0}};
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_neg   <= w_sa ^ w_sb;
            r_mcand <= w_mag_a;
            r_hi    <= {WIDTH{1'b0}};
            r_lo    <= w_mag_b;
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        ST_CALC: begin
          if (!abort) begin
            r_hi  <= w_sum[WIDTH:1];
            r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FIX: begin
          if (!abort) begin
            r_product <= w_prod_fix;
            r_result  <= (r_mode == MODE_MUL) ? w_prod_fix[WIDTH-1:0]
                                              : w_prod_fix[2*WIDTH-1:WIDTH];
            r_done    <= 1'b1;
          end
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
  assign result  = r_result;

endmodule

// File: tb/tb_seq_mul_param.sv
// Scoreboard bench for seq_mul_param: WIDTH=64 main instance plus a WIDTH=8 instance.
module tb_seq_mul_param;

  localparam int W  = 64;
  localparam int W8 = 8;

  localparam logic [1:0] M_MUL    = 2'b00;
  localparam logic [1:0] M_MULH   = 2'b01;
  localparam logic [1:0] M_MULHSU = 2'b10;
  localparam logic [1:0] M_MULHU  = 2'b11;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Rst, start, abort;
  logic [1:0]       mode;
  logic [W-1:0]     mcand, mplier;
  logic             busy, done;
  logic [2*W-1:0]   product;
  logic [W-1:0]     result;

  logic             start8, abort8;
  logic [1:0]       mode8;
  logic [W8-1:0]    mcand8, mplier8;
  logic             busy8, done8;
  logic [2*W8-1:0]  product8;
  logic [W8-1:0]    result8;

  seq_mul_param #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort), .mode(mode),
    .multiplicand(mcand), .multiplier(mplier),
    .busy(busy), .done(done), .product(product), .result(result)
  );

  seq_mul_param #(.WIDTH(W8)) dut8 (
    .Clk(Clk), .Rst(Rst), .start(start8), .abort(abort8), .mode(mode8),
    .multiplicand(mcand8), .multiplier(mplier8),
    .busy(busy8), .done(done8), .product(product8), .result(result8)
  );

  typedef struct {
    logic [2*W-1:0] p;
    logic [W-1:0]   r;
    longint         due;
  } exp_t;

  exp_t   q[$];
  exp_t   q8[$];
  exp_t   e64, e8;
  int     checks = 0;
  int     errors = 0;
  int     done_cnt = 0;
  int     busy_run = 0;
  longint cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Monitor for the 64-bit instance.
  always @(negedge Clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got product=%h want=no_done", product);
      end else begin
        e64 = q.pop_front();
        check("product", product, e64.p);
        check("result", {{W{1'b0}}, result}, {{W{1'b0}}, e64.r});
        check("latency_cycle", 128'(cyc), 128'(e64.due));
        check("busy_cycles", 128'(busy_run), 128'(W + 1));
      end
    end
    if (busy === 1'b1) busy_run++;
    else busy_run = 0;
  end

  // Monitor for the 8-bit instance.
  always @(negedge Clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done8 got product=%h want=no_done", product8);
      end else begin
        e8 = q8.pop_front();
        check("product8", 128'(product8), 128'(e8.p[2*W8-1:0]));
        check("result8", 128'(result8), 128'(e8.r[W8-1:0]));
        check("latency8_cycle", 128'(cyc), 128'(e8.due));
      end
    end
  end

  // Caller is positioned at a negedge; drives one start pulse.
  task automatic issue(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] ep, input logic [W-1:0] er, input bit accepted);
    mode = m; mcand = a; mplier = b; start = 1'b1;
    @(posedge Clk);
    #1;
    start = 1'b0;
    if (accepted) q.push_back('{p: ep, r: er, due: cyc + W + 1});
  endtask

  task automatic wait_drain(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (q.size() == 0 && q8.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_timeout", 128'(ok), 128'(1));
  endtask

  task automatic run(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [2*W-1:0] ep, input logic [W-1:0] er);
    @(negedge Clk);
    issue(m, a, b, ep, er, 1'b1);
    wait_drain(W + 10);
  endtask

  initial begin
    int  dc;
    bit  seen;
    Rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'b00; mcand = '0; mplier = '0;
    start8 = 1'b0; abort8 = 1'b0; mode8 = 2'b00; mcand8 = '0; mplier8 = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_done", 128'(done), 128'(0));
    check("rst_product", product, 128'(0));
    check("rst_result", 128'(result), 128'(0));
    @(negedge Clk);
    Rst = 1'b0;

    // Basic unsigned/signed cases.
    run(M_MUL, 64'd120, 64'd29, 128'd3480, 64'd3480);
    run(M_MULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1, 64'd0);
    run(M_MULH, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
        128'h4000_0000_0000_0000_0000_0000_0000_0000, 64'h4000_0000_0000_0000);
    run(M_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE);
    run(M_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
        128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
    run(M_MULH, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
        128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFF);
    run(M_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
        128'h0000_0000_0000_0004_FFFF_FFFF_FFFF_FFF1, 64'hFFFF_FFFF_FFFF_FFF1);
    run(M_MULH, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 128'd0, 64'd0);

    // Start while busy is ignored; restart in the done cycle.
    @(negedge Clk);
    issue(M_MUL, 64'd84, 64'd30, 128'd2520, 64'd2520, 1'b1);
    repeat (9) @(negedge Clk);
    issue(M_MUL, 64'd120, 64'd84, 128'd0, 64'd0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < W + 10; i++) begin
      @(negedge Clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 128'(seen), 128'(1));
    issue(M_MUL, 64'd120, 64'd84, 128'd10080, 64'd10080, 1'b1);
    wait_drain(W + 10);

    // Reset mid-operation kills it without a done.
    @(negedge Clk);
    issue(M_MUL, 64'd30, 64'd29, 128'd870, 64'd870, 1'b1);
    repeat (19) @(negedge Clk);
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    q.delete();
    check("midrst_busy", 128'(busy), 128'(0));
    check("midrst_product", product, 128'(0));
    check("midrst_result", 128'(result), 128'(0));
    dc = done_cnt;
    repeat (W + 10) @(negedge Clk);
    check("midrst_no_done", 128'(done_cnt), 128'(dc));
    run(M_MUL, 64'd30, 64'd29, 128'd870, 64'd870);

    // Abort mid-operation keeps the previous result.
    run(M_MUL, 64'd120, 64'd28, 128'd3360, 64'd3360);
    @(negedge Clk);
    issue(M_MUL, 64'd30, 64'd29, 128'd870, 64'd870, 1'b1);
    repeat (4) @(negedge Clk);
    abort = 1'b1;
    @(posedge Clk);
    #1;
    abort = 1'b0;
    q.delete();
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_product", product, 128'd3360);
    check("abort_result", 128'(result), 128'd3360);
    dc = done_cnt;
    repeat (W + 10) @(negedge Clk);
    check("abort_no_done", 128'(done_cnt), 128'(dc));

    // Abort together with start in IDLE: start wins.
    @(negedge Clk);
    abort = 1'b1;
    issue(M_MUL, 64'd7, 64'd6, 128'd42, 64'd42, 1'b1);
    abort = 1'b0;
    wait_drain(W + 10);

    // Narrow instance: MULH -128 * 127.
    @(negedge Clk);
    mode8 = M_MULH; mcand8 = 8'h80; mplier8 = 8'h7F; start8 = 1'b1;
    @(posedge Clk);
    #1;
    start8 = 1'b0;
    q8.push_back('{p: 128'h0000_0000_0000_0000_0000_0000_0000_C080,
                   r: 64'h0000_0000_0000_00C0, due: cyc + W8 + 1});
    wait_drain(W8 + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
